// File: rtl/mult_rr_arbiter.sv
// ============================================================================
// mult_rr_arbiter
//
// Lets NREQ requesters share one combinational 3x3 unsigned multiplier.
// A round-robin arbiter grants at most one operand pair per cycle. The
// 6-bit product is returned through a single-entry registered output stage,
// tagged with the ID of the requester that owns it.
//
// Ports
//   clk        in   1        clock, all state on the rising edge
//   rst        in   1        asynchronous, active-high reset
//   req_valid  in   NREQ     requester i has an operand pair pending
//   req_ready  out  NREQ     requester i's pair is accepted this cycle (one-hot or zero)
//   req_a      in   3*NREQ   operand A, requester i at [3i+2:3i]
//   req_b      in   3*NREQ   operand B, same packing
//   res_valid  out  1        the product register holds a result
//   res_ready  in   1        downstream takes the result this cycle
//   res_id     out  IDW      requester that owns res_p
//   res_p      out  6        unsigned product a*b
// ============================================================================

// ----------------------------------------------------------------------------
// mult3x3: 3x3 unsigned array multiplier (sum of shifted partial products)
// ----------------------------------------------------------------------------
module mult3x3 (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    output logic [5:0] p_o
);

    logic [5:0] pp0;
    logic [5:0] pp1;
    logic [5:0] pp2;

    assign pp0 = {3'b000, a_i & {3{b_i[0]}}};
    assign pp1 = {2'b00,  a_i & {3{b_i[1]}}, 1'b0};
    assign pp2 = {1'b0,   a_i & {3{b_i[2]}}, 2'b00};

    // 7*7 = 49 fits in 6 bits, so the sum cannot overflow.
    assign p_o = pp0 + pp1 + pp2;

endmodule

// ----------------------------------------------------------------------------
// mult_rr_arbiter: top
// ----------------------------------------------------------------------------
module mult_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_a,
    input  logic [3*NREQ-1:0]     req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [5:0]            res_p
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [5:0]      p_q,     p_d;
    logic [IDW-1:0]  id_q,    id_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW:0]    idx_w;
    logic            can_accept;
    logic            accept;
    logic [2:0]      a_mux;
    logic [2:0]      b_mux;
    logic [5:0]      mult_p;

    // ------------------------------------------------------------------
    // Round-robin search: walk ptr, ptr+1, ... wrapping at NREQ. One extra
    // bit on idx_w lets the wrap be a single conditional subtract, which
    // also works when NREQ is not a power of two.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NREQ)) begin
                idx_w = idx_w - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[idx_w[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_w[IDW-1:0];
            end
        end
    end

    // The register can take a new result when empty, or when the current
    // one drains this same cycle (zero-bubble throughput). The handshake
    // depends only on valid/ready/state/ptr, never on operand values.
    assign can_accept = (state_q == EMPTY) || res_ready;
    assign accept     = gnt_found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand mux written as a compare loop so that every slice bound is
    // a constant.
    always_comb begin
        a_mux = '0;
        b_mux = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                a_mux = req_a[3*k +: 3];
                b_mux = req_b[3*k +: 3];
            end
        end
    end

    mult3x3 u_mult (
        .a_i (a_mux),
        .b_i (b_mux),
        .p_o (mult_p)
    );

    // ------------------------------------------------------------------
    // Output stage next-state: load on accept, drain when downstream takes
    // the result, otherwise hold. Priority rotates only on accept.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        p_d     = p_q;
        id_d    = id_q;
        if (accept) begin
            state_d = FULL;
            p_d     = mult_p;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            p_q     <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            p_q     <= p_d;
            id_q    <= id_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_p     = p_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// ============================================================================
// tb_mult_rr_arbiter
//
// Directed bench for mult_rr_arbiter with NREQ=4. A table of per-cycle
// records (inputs, expected req_ready before the edge, expected result
// after the edge) is replayed in order from reset. Hand-written sequences
// then sweep all operand pairs and exercise an asynchronous reset while a
// result is held under backpressure.
// ============================================================================
module tb_mult_rr_arbiter;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_a;
    logic [3*NREQ-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_id;
    logic [5:0]        res_p;

    int checks = 0;
    int errors = 0;

    mult_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  vld;
        logic [11:0] a;
        logic [11:0] b;
        logic        rr;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [5:0]  exp_p;
        logic [1:0]  exp_id;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic logic [11:0] pk(input logic [2:0] x0, input logic [2:0] x1,
                                       input logic [2:0] x2, input logic [2:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic vec_t mkv(input logic [3:0] vld, input logic [11:0] a,
                                 input logic [11:0] b, input logic rr,
                                 input logic [3:0] rdy, input logic ev,
                                 input logic [5:0] ep, input logic [1:0] eid);
        vec_t v;
        v.vld = vld; v.a = a; v.b = b; v.rr = rr;
        v.exp_rdy = rdy; v.exp_vld = ev; v.exp_p = ep; v.exp_id = eid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [11:0] zero3;
        logic [2:0]  ta;
        logic [2:0]  tb;
        logic [5:0]  exp_p;

        zero3 = '0;

        // Rotation with all requesters valid: a_i = i+1, b_i = 3.
        vecs[0]  = mkv(4'b1111, pk(3'd1,3'd2,3'd3,3'd4), pk(3'd3,3'd3,3'd3,3'd3), 1'b1, 4'b0001, 1'b1, 6'd3,  2'd0);
        vecs[1]  = mkv(4'b1111, pk(3'd1,3'd2,3'd3,3'd4), pk(3'd3,3'd3,3'd3,3'd3), 1'b1, 4'b0010, 1'b1, 6'd6,  2'd1);
        vecs[2]  = mkv(4'b1111, pk(3'd1,3'd2,3'd3,3'd4), pk(3'd3,3'd3,3'd3,3'd3), 1'b1, 4'b0100, 1'b1, 6'd9,  2'd2);
        vecs[3]  = mkv(4'b1111, pk(3'd1,3'd2,3'd3,3'd4), pk(3'd3,3'd3,3'd3,3'd3), 1'b1, 4'b1000, 1'b1, 6'd12, 2'd3);
        vecs[4]  = mkv(4'b1111, pk(3'd1,3'd2,3'd3,3'd4), pk(3'd3,3'd3,3'd3,3'd3), 1'b1, 4'b0001, 1'b1, 6'd3,  2'd0);
        // Single request from requester 2: 5*6.
        vecs[5]  = mkv(4'b0100, pk(3'd0,3'd0,3'd5,3'd0), pk(3'd0,3'd0,3'd6,3'd0), 1'b1, 4'b0100, 1'b1, 6'd30, 2'd2);
        // Idle drain: register empties, values hold; ptr stays at 3.
        vecs[6]  = mkv(4'b0000, zero3, zero3, 1'b1, 4'b0000, 1'b0, 6'd30, 2'd2);
        // Priority wrap from ptr=3 with requesters 1 and 3 valid.
        vecs[7]  = mkv(4'b1010, pk(3'd0,3'd2,3'd0,3'd6), pk(3'd0,3'd3,3'd0,3'd5), 1'b1, 4'b1000, 1'b1, 6'd30, 2'd3);
        vecs[8]  = mkv(4'b1010, pk(3'd0,3'd2,3'd0,3'd6), pk(3'd0,3'd3,3'd0,3'd5), 1'b1, 4'b0010, 1'b1, 6'd6,  2'd1);
        // Backpressure: load 7*7, then hold for 3 cycles with a request waiting.
        vecs[9]  = mkv(4'b0100, pk(3'd0,3'd0,3'd7,3'd0), pk(3'd0,3'd0,3'd7,3'd0), 1'b1, 4'b0100, 1'b1, 6'd49, 2'd2);
        vecs[10] = mkv(4'b0001, pk(3'd1,3'd0,3'd0,3'd0), pk(3'd2,3'd0,3'd0,3'd0), 1'b0, 4'b0000, 1'b1, 6'd49, 2'd2);
        vecs[11] = mkv(4'b0001, pk(3'd1,3'd0,3'd0,3'd0), pk(3'd2,3'd0,3'd0,3'd0), 1'b0, 4'b0000, 1'b1, 6'd49, 2'd2);
        vecs[12] = mkv(4'b0001, pk(3'd1,3'd0,3'd0,3'd0), pk(3'd2,3'd0,3'd0,3'd0), 1'b0, 4'b0000, 1'b1, 6'd49, 2'd2);
        // res_ready rises: waiting request accepted in the same cycle.
        vecs[13] = mkv(4'b0001, pk(3'd1,3'd0,3'd0,3'd0), pk(3'd2,3'd0,3'd0,3'd0), 1'b1, 4'b0001, 1'b1, 6'd2,  2'd0);
        // Boundary operands.
        vecs[14] = mkv(4'b0010, pk(3'd0,3'd0,3'd0,3'd0), pk(3'd0,3'd7,3'd0,3'd0), 1'b1, 4'b0010, 1'b1, 6'd0,  2'd1);
        vecs[15] = mkv(4'b0100, pk(3'd0,3'd0,3'd7,3'd0), pk(3'd0,3'd0,3'd1,3'd0), 1'b1, 4'b0100, 1'b1, 6'd7,  2'd2);
        vecs[16] = mkv(4'b1000, pk(3'd0,3'd0,3'd0,3'd4), pk(3'd0,3'd0,3'd0,3'd4), 1'b1, 4'b1000, 1'b1, 6'd16, 2'd3);
        // Hold with nothing pending, then drain.
        vecs[17] = mkv(4'b0000, zero3, zero3, 1'b0, 4'b0000, 1'b1, 6'd16, 2'd3);
        vecs[18] = mkv(4'b0000, zero3, zero3, 1'b1, 4'b0000, 1'b0, 6'd16, 2'd3);

        // Reset with requests pending: no grants, outputs cleared.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_p",     32'(res_p),     32'd0);
        check("rst_res_id",    32'(res_id),    32'd0);
        req_valid = '0;
        rst       = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            req_valid = vecs[i].vld;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            res_ready = vecs[i].rr;
            #1;
            check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d_res_p", i),     32'(res_p),     32'(vecs[i].exp_p));
            check($sformatf("vec%0d_res_id", i),    32'(res_id),    32'(vecs[i].exp_id));
        end

        // Exhaustive operand sweep through requester 0.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                ta        = 3'(a);
                tb        = 3'(b);
                exp_p     = 6'(a * b);
                req_valid = 4'b0001;
                req_a     = {9'd0, ta};
                req_b     = {9'd0, tb};
                res_ready = 1'b1;
                #1;
                check($sformatf("sweep_%0dx%0d_ready", a, b), 32'(req_ready), 32'd1);
                @(posedge clk);
                #1;
                check($sformatf("sweep_%0dx%0d_p", a, b),  32'(res_p),  32'(exp_p));
                check($sformatf("sweep_%0dx%0d_id", a, b), 32'(res_id), 32'd0);
            end
        end

        // Reset mid-operation: load 7*7 from requester 2 (ptr moves to 3),
        // hold it under backpressure, then reset asynchronously.
        req_valid = 4'b0100;
        req_a     = pk(3'd0, 3'd3, 3'd7, 3'd2);
        req_b     = pk(3'd0, 3'd5, 3'd7, 3'd2);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid_load_p",     32'(res_p),     32'd49);
        check("mid_load_valid", 32'(res_valid), 32'd1);
        req_valid = 4'b1010;
        res_ready = 1'b0;
        #1;
        check("mid_bp_ready", 32'(req_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_p",     32'(res_p),     32'd0);
        check("mid_rst_id",    32'(res_id),    32'd0);
        res_ready = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        // ptr restarts at 0, so requester 1 wins over 3.
        check("post_rst_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(res_valid), 32'd1);
        check("post_rst_id",    32'(res_id),    32'd1);
        check("post_rst_p",     32'(res_p),     32'd15);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Shares one combinational 3x3 unsigned multiplier (the team's existing `mult3x3` array, instantiated inside) among NREQ requesters in the TPU datapath. Requesters present operand pairs over valid/ready handshakes, a round-robin arbiter grants one request per cycle, and the 6-bit product is returned through a single-entry registered output stage tagged with the requester ID. Downstream accumulators consume results over a valid/ready handshake with full backpressure.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..16.
- `IDW`, `$clog2(NREQ)`, width of the requester ID; derived, not overridden.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i has an operand pair pending.
- `req_ready`  out  NREQ  bit i: requester i's pair is accepted this cycle; at most one bit high.
- `req_a`  in  3*NREQ  operand A, requester i at bits [3i+2:3i].
- `req_b`  in  3*NREQ  operand B, same packing.
- `res_valid`  out  1  product register holds a result.
- `res_ready`  in  1  downstream accepts the result this cycle.
- `res_id`  out  IDW  index of the requester that owns `res_p`.
- `res_p`  out  6  unsigned product a*b.

## Operation
- Output stage state machine, two states:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- `can_accept` = EMPTY, or (FULL and `res_ready`).
- Arbitration, combinational:
  - Search `req_valid` starting at index `ptr`, ascending, wrapping from NREQ-1 to 0.
  - The first asserted index is the grant `g`.
- `req_ready[g]`=1 only when `can_accept` and some `req_valid` is high. All other bits are 0.
- `req_ready` never asserts for a requester whose `req_valid` is low.
- Accept means `req_valid[g]` and `req_ready[g]` are both high. On accept:
  - `res_p` <= `req_a[g]` * `req_b[g]`, computed by the internal `mult3x3` on the muxed operands.
  - `res_id` <= g.
  - State goes to FULL.
  - `ptr` <= (g+1) mod NREQ.
- FULL and `res_ready` with no accept that cycle: state goes to EMPTY. `res_p` and `res_id` hold their last values.
- FULL and `res_ready` low: `res_valid`, `res_p` and `res_id` hold stable. No accept happens, so all `req_ready` are 0.
- FULL, `res_ready` and a new accept in the same cycle: the old result drains and the new one loads. State stays FULL, giving zero-bubble throughput.
- `ptr` changes only on accept. Idle cycles do not rotate priority.
- Arithmetic: unsigned 3-bit x 3-bit gives a 6-bit product; the maximum is 7*7=49, so no overflow is possible.
- Requesters are expected to hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted. The block samples the operands only in the accept cycle.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - `res_valid`=0, `res_p`=0, `res_id`=0, `ptr`=0, state EMPTY.
  - `req_ready`=0 while `rst` is high.
  - Any pending result is discarded.
- Latency: a request accepted at edge N shows `res_valid`=1 with its product after edge N.
- Throughput: one result per cycle while `res_ready` is held high.
- `req_ready` is combinational from `req_valid`, `res_ready`, state and `ptr`. There is no combinational path from `req_a`/`req_b` to any handshake signal.
- Fairness: a requester holding `req_valid` continuously is granted within NREQ accepts.
- The `mult3x3` path is a single-cycle combinational path: operand mux, then multiplier, then `res_p` register.

## Test plan
- Single request: after reset, requester 2 presents a=5, b=6 with `res_ready`=1.
  - `req_ready`=4'b0100 in the same cycle.
  - Next cycle `res_valid`=1, `res_p`=30, `res_id`=2.
- All-request rotation: NREQ=4, all `req_valid`=1 continuously, `res_ready`=1.
  - Grants go 0,1,2,3,0,... one per cycle.
  - `res_id` follows the same sequence, with no idle cycles.
- Backpressure: result loaded (a=7, b=7) and `res_ready`=0 for 3 cycles.
  - `res_valid` stays 1, with `res_p`=49 and `res_id` unchanged.
  - `req_ready`=0 throughout.
  - When `res_ready` rises, the next request is accepted that same cycle.
- Priority wrap: `ptr`=3, requesters 1 and 3 valid.
  - Requester 3 is granted and `ptr` becomes 0.
  - Requester 1 is granted next.
- Boundary operands: a=0, b=7 gives 0; a=7, b=1 gives 7; a=4, b=4 gives 16.
  - Exhaustive sweep of all 64 operand pairs through requester 0 matches a*b.
- Reset mid-operation: assert `rst` while FULL with `res_ready`=0.
  - `res_valid`, `res_p` and `res_id` clear immediately.
  - After release, the first grant goes to the lowest valid index starting from 0.
